seq_det_event_monitor: RTL

- Downstream consumer of the serial-pattern detector's 1-cycle match pulse.
- Counts match pulses over a programmable window of clock cycles and latches the window result into a holding register.
- Flags when the count reaches a threshold, and flags results lost because software did not read them in time.
- Supports one-shot and continuous back-to-back windows; results are read through a valid/ack handshake.

---
 rtl/seq_det_pkg.sv | 23 ++
 rtl/seq_det_event_monitor_sat_counter.sv | 27 ++
 rtl/seq_det_event_monitor.sv | 131 +++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types, defaults and saturating increment for the event monitor
package seq_det_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIN_W = 8;
  localparam int DEF_CNT_W = 4;

  // Adds inc to value but holds at the all-ones value of the given width.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic inc,
                                          input int width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    if (inc && (value != max_val)) begin
      return value + 32'd1;
    end
    return value;
  endfunction

endpackage

// File: rtl/seq_det_event_monitor_sat_counter.sv
// rtl/seq_det_event_monitor_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_value
);

  logic [W-1:0] r_value;

  // Clear has priority over increment; increment never wraps past all-ones.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_value <= '0;
    end else begin
      r_value <= W'(sat_inc(32'(r_value), i_inc, W));
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/seq_det_event_monitor.sv
// rtl/seq_det_event_monitor.sv - windowed match-pulse counter with held result and overrun flag
module seq_det_event_monitor
  import seq_det_pkg::*;
#(
  parameter int WIN_W = DEF_WIN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_det_pulse,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_cont,
  input  logic [WIN_W-1:0] i_win_len,
  input  logic [CNT_W-1:0] i_thresh,
  input  logic             i_rd_ack,
  output logic             o_busy,
  output logic             o_res_valid,
  output logic [CNT_W-1:0] o_res_count,
  output logic             o_alarm,
  output logic             o_overrun
);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIN_W-1:0]   r_remaining;
  logic [WIN_W-1:0]   r_win_len_l;
  logic [CNT_W-1:0]   r_thresh_l;
  logic               r_cont_l;
  logic               r_res_valid;
  logic [CNT_W-1:0]   r_res_count;
  logic               r_alarm;
  logic               r_overrun;

  logic [CNT_W-1:0]   w_acc;
  logic [CNT_W-1:0]   w_acc_next;
  logic               w_accept;
  logic               w_run;
  logic               w_win_end;
  logic               w_ovr_evt;
  logic               w_acc_clr;

  assign w_run      = (r_state == RUN);
  assign w_accept   = (r_state == IDLE) && i_start && (i_win_len != '0);
  // A stop on the final window edge aborts the window instead of ending it.
  assign w_win_end  = w_run && !i_stop && (r_remaining == WIN_W'(1));
  assign w_ovr_evt  = w_win_end && r_res_valid && !i_rd_ack;
  assign w_acc_next = CNT_W'(sat_inc(32'(w_acc), i_det_pulse, CNT_W));
  // Accumulator sits at zero while idle, so an accepted start begins from zero.
  assign w_acc_clr  = !w_run || i_stop || w_win_end;

  sat_counter #(.W(CNT_W)) u_acc (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_acc_clr),
    .i_inc   (i_det_pulse),
    .o_value (w_acc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: enter RUN on an accepted start, leave on stop or a one-shot window end.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = RUN;
      RUN: begin
        if (i_stop) begin
          w_state_next = IDLE;
        end else if (w_win_end && !r_cont_l) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Window configuration latch and down-counter; continuous mode reloads with no gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_remaining <= '0;
      r_win_len_l <= '0;
      r_thresh_l  <= '0;
      r_cont_l    <= 1'b0;
    end else if (w_accept) begin
      r_remaining <= i_win_len;
      r_win_len_l <= i_win_len;
      r_thresh_l  <= i_thresh;
      r_cont_l    <= i_cont;
    end else if (w_run && !i_stop) begin
      r_remaining <= w_win_end ? r_win_len_l : r_remaining - WIN_W'(1);
    end
  end

  // Held result, read handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_count <= '0;
      r_alarm     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_win_end) begin
        r_res_count <= w_acc_next;
        r_alarm     <= (w_acc_next >= r_thresh_l);
        r_res_valid <= 1'b1;
      end else if (i_rd_ack && r_res_valid) begin
        r_res_valid <= 1'b0;
      end
      if (w_ovr_evt) begin
        r_overrun <= 1'b1;
      end else if (i_rd_ack) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_busy      = w_run;
  assign o_res_valid = r_res_valid;
  assign o_res_count = r_res_count;
  assign o_alarm     = r_alarm;
  assign o_overrun   = r_overrun;

endmodule
